// File: rtl/wb_burst_bridge.sv
// Request-to-Wishbone burst bridge. Queued read/write bursts are replayed as
// registered-feedback Wishbone cycles, with write data and read data held in FIFOs.

module wb_burst_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module wb_burst_bridge #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 4,
  parameter int WRAP_BITS  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic                       req_wrap,
  input  logic [LEN_W-1:0]           req_len,
  input  logic [DW/8-1:0]            req_mask,
  input  logic [AW-1:0]              req_addr,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [DW-1:0]              din,
  output logic                       dout_valid,
  input  logic                       dout_ack,
  output logic [DW-1:0]              dout,
  output logic                       dout_err,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [DW/8-1:0]            wb_sel_o,
  output logic [AW-$clog2(DW/8)-1:0] wb_adr_o,
  output logic [DW-1:0]              wb_dat_o,
  output logic [2:0]                 wb_cti_o,
  output logic [1:0]                 wb_bte_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  input  logic [DW-1:0]              wb_dat_i,
  output logic                       busy,
  output logic                       err_o,
  input  logic                       err_clr,
  output logic [1:0]                 state_dbg
);
  localparam int COLS = DW / 8;
  localparam int AB   = $clog2(COLS);
  localparam int WA   = AW - AB;
  localparam int RW   = 2 + LEN_W + COLS + AW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [1:0]       WRAP_BTE = 2'(WRAP_BITS - 1);

  logic [1:0]       state;
  logic             stb;
  logic             err_q;
  logic             w_we;
  logic             w_wrap;
  logic [LEN_W-1:0] w_len;
  logic [COLS-1:0]  w_mask;
  logic [WA-1:0]    w_adr;
  logic [LEN_W-1:0] drain_cnt;

  logic [RW-1:0]    req_wdata;
  logic [RW-1:0]    req_rdata;
  logic             req_empty;
  logic             req_full;
  logic             req_pop;
  logic             h_we;
  logic             h_wrap;
  logic [LEN_W-1:0] h_len;
  logic [COLS-1:0]  h_mask;
  logic [AW-1:0]    h_addr;
  logic             unused_addr_lo;

  logic [DW-1:0]    din_rdata;
  logic             din_empty;
  logic             din_full;
  logic             din_pop;

  logic [DW:0]      dout_rdata;
  logic             dout_empty;
  logic             dout_full;
  logic             dout_push;

  logic             beat_end;
  logic             issue;
  logic [WRAP_BITS-1:0] wrap_lo;
  logic [WA-1:0]    adr_next;

  assign req_wdata = {req_we, req_wrap, req_len, req_mask, req_addr};
  assign h_we      = req_rdata[RW-1];
  assign h_wrap    = req_rdata[RW-2];
  assign h_len     = req_rdata[RW-3 -: LEN_W];
  assign h_mask    = req_rdata[AW +: COLS];
  assign h_addr    = req_rdata[AW-1:0];
  // Byte offset within the word has no meaning on a word-addressed bus.
  assign unused_addr_lo = ^h_addr[AB-1:0];

  wb_burst_bridge_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (req_valid),
    .wdata (req_wdata),
    .pop   (req_pop),
    .rdata (req_rdata),
    .empty (req_empty),
    .full  (req_full)
  );

  wb_burst_bridge_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_din_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (din_valid),
    .wdata (din),
    .pop   (din_pop),
    .rdata (din_rdata),
    .empty (din_empty),
    .full  (din_full)
  );

  wb_burst_bridge_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_dout_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (dout_push),
    .wdata ({wb_err_i, wb_dat_i}),
    .pop   (dout_ack),
    .rdata (dout_rdata),
    .empty (dout_empty),
    .full  (dout_full)
  );

  // A beat ends on ack or err while strobing; err wins when both are present.
  assign beat_end  = stb && (wb_ack_i || wb_err_i);
  assign issue     = w_we ? !din_empty : !dout_full;
  assign req_pop   = (state == IDLE) && !req_empty;
  assign din_pop   = ((state == XFER) && beat_end && w_we) ||
                     ((state == DRAIN) && !din_empty);
  assign dout_push = (state == XFER) && beat_end && !w_we;

  always_comb begin
    wrap_lo  = w_adr[WRAP_BITS-1:0] + 1'b1;
    adr_next = w_adr + 1'b1;
    if (w_wrap) adr_next = {w_adr[WA-1:WRAP_BITS], wrap_lo};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      stb       <= 1'b0;
      w_we      <= 1'b0;
      w_wrap    <= 1'b0;
      w_len     <= '0;
      w_mask    <= '0;
      w_adr     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_empty) begin
            w_we   <= h_we;
            w_wrap <= h_wrap;
            w_len  <= h_len;
            w_mask <= h_mask;
            w_adr  <= h_addr[AW-1:AB];
            if (h_len != '0) state <= XFER;
          end
        end
        XFER: begin
          if (!stb) begin
            stb <= issue;
          end else if (beat_end) begin
            stb <= 1'b0;
            if (wb_err_i) begin
              // Aborted write: the unsent beats' data still has to be consumed.
              if (w_we && (w_len != LEN_ONE)) begin
                drain_cnt <= w_len - 1'b1;
                state     <= DRAIN;
              end else begin
                state <= IDLE;
              end
            end else if (w_len == LEN_ONE) begin
              state <= IDLE;
            end else begin
              w_len <= w_len - 1'b1;
              w_adr <= adr_next;
            end
          end
        end
        DRAIN: begin
          if (!din_empty) begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == LEN_ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (stb && wb_err_i) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign wb_cyc_o   = stb;
  assign wb_stb_o   = stb;
  assign wb_we_o    = w_we;
  assign wb_sel_o   = w_mask;
  assign wb_adr_o   = w_adr;
  assign wb_cti_o   = (state != XFER) ? 3'b000 : ((w_len == LEN_ONE) ? 3'b111 : 3'b010);
  assign wb_bte_o   = ((state == XFER) && w_wrap) ? WRAP_BTE : 2'b00;
  assign wb_dat_o   = din_empty ? '0 : din_rdata;

  assign dout_valid = !dout_empty;
  assign dout       = dout_empty ? '0 : dout_rdata[DW-1:0];
  assign dout_err   = dout_empty ? 1'b0 : dout_rdata[DW];

  assign req_ready  = !req_full;
  assign din_ready  = !din_full;
  assign busy       = (state != IDLE) || !req_empty;
  assign err_o      = err_q;
  assign state_dbg  = state;
endmodule

// File: tb/tb_wb_burst_bridge.sv
// Directed scoreboard bench for wb_burst_bridge: expected bus beats and read
// data are queued at stimulus time and checked by independent monitors.

module tb_wb_burst_bridge;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_wrap = 1'b0;
  logic [3:0]  req_len = '0;
  logic [3:0]  req_mask = '0;
  logic [31:0] req_addr = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] din = '0;
  logic        dout_valid;
  logic        dout_ack = 1'b0;
  logic [31:0] dout;
  logic        dout_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [29:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic        busy;
  logic        err_o;
  logic        err_clr = 1'b0;
  logic [1:0]  state_dbg;

  logic [71:0] bus_exp_q[$];
  logic [32:0] rd_exp_q[$];
  int tests = 0;
  int fails = 0;
  int beat_cnt = 0;
  int err_at = -1;
  bit slave_stall = 1'b0;
  bit pop_en = 1'b1;

  wb_burst_bridge #(.DW(32), .AW(32), .FIFO_DEPTH(4), .LEN_W(4), .WRAP_BITS(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wrap(req_wrap),
    .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ack(dout_ack), .dout(dout), .dout_err(dout_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i),
    .busy(busy), .err_o(err_o), .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] beat(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                                       input logic [2:0] cti, input logic [1:0] bte, input logic [31:0] dat);
    return {we, adr, sel, cti, bte, dat};
  endfunction

  // Wishbone slave (zero-wait, optional stall / error) plus bus-beat monitor
  always @(negedge clk_i) begin
    logic [71:0] exp_b;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_stb_o && wb_cyc_o && !slave_stall) begin
      wb_dat_i = {16'hC0DE, wb_adr_o[15:0]};
      if (beat_cnt == err_at) wb_err_i = 1'b1;
      else wb_ack_i = 1'b1;
      if (bus_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_unexpected: got beat adr %0h, required no beat", wb_adr_o);
      end else begin
        exp_b = bus_exp_q.pop_front();
        check("bus_beat", {wb_we_o, wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_dat_o}, exp_b);
      end
      beat_cnt++;
    end
  end

  // Read-data monitor: pops dout whenever it is presented and popping is enabled
  always @(negedge clk_i) begin
    logic [32:0] exp_r;
    dout_ack = 1'b0;
    if (rst_ni && pop_en && dout_valid) begin
      if (rd_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dout_unexpected: got %0h, required no entry", {dout_err, dout});
      end else begin
        exp_r = rd_exp_q.pop_front();
        check("dout", {dout_err, dout}, exp_r);
      end
      dout_ack = 1'b1;
    end
  end

  // Driver tasks
  task automatic push_req(input logic we, input logic wrap, input logic [3:0] len,
                          input logic [3:0] mask, input logic [31:0] addr);
    int n = 0;
    @(negedge clk_i);
    while (!req_ready && n < 50) begin @(negedge clk_i); n++; end
    req_valid = 1'b1; req_we = we; req_wrap = wrap;
    req_len = len; req_mask = mask; req_addr = addr;
    @(negedge clk_i);
    req_valid = 1'b0;
  endtask

  task automatic push_din(input logic [31:0] d);
    int n = 0;
    @(negedge clk_i);
    while (!din_ready && n < 50) begin @(negedge clk_i); n++; end
    din_valid = 1'b1; din = d;
    @(negedge clk_i);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk_i); n++; end
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_rd_drain(input string name, input int budget);
    int n = 0;
    while (rd_exp_q.size() != 0 && n < budget) begin @(negedge clk_i); n++; end
    check({name, "_rd_drain"}, rd_exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset state
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_dat_o}, '0);
    check("rst_dout", {dout_valid, dout_err, dout}, '0);
    check("rst_flags", {req_ready, din_ready, busy, err_o, state_dbg}, 6'b110000);

    // Linear read, len 4, addr 0x100
    for (int i = 0; i < 4; i++) begin
      bus_exp_q.push_back(beat(1'b0, 30'h40 + 30'(i), 4'hF, (i == 3) ? 3'b111 : 3'b010, 2'b00, 32'h0));
      rd_exp_q.push_back({1'b0, 32'hC0DE0040 + 32'(i)});
    end
    push_req(1'b0, 1'b0, 4'd4, 4'hF, 32'h100);
    check("lin_busy_high", busy, 1'b1);
    wait_idle("lin", 60);
    wait_rd_drain("lin", 20);

    // Wrapping write, len 4, addr 0x10C, mask 0110
    push_din(32'h1111_0001);
    push_din(32'h2222_0002);
    push_din(32'h3333_0003);
    push_din(32'h4444_0004);
    bus_exp_q.push_back(beat(1'b1, 30'h43, 4'b0110, 3'b010, 2'b01, 32'h1111_0001));
    bus_exp_q.push_back(beat(1'b1, 30'h40, 4'b0110, 3'b010, 2'b01, 32'h2222_0002));
    bus_exp_q.push_back(beat(1'b1, 30'h41, 4'b0110, 3'b010, 2'b01, 32'h3333_0003));
    bus_exp_q.push_back(beat(1'b1, 30'h42, 4'b0110, 3'b111, 2'b01, 32'h4444_0004));
    push_req(1'b1, 1'b1, 4'd4, 4'b0110, 32'h10C);
    wait_idle("wrap", 60);
    check("wrap_din_empty", wb_dat_o, 32'h0);

    // Read len 8 into a depth-4 dout FIFO with no pops
    @(negedge clk_i);
    pop_en = 1'b0;
    base = beat_cnt;
    for (int i = 0; i < 8; i++) begin
      bus_exp_q.push_back(beat(1'b0, 30'h80 + 30'(i), 4'hF, (i == 7) ? 3'b111 : 3'b010, 2'b00, 32'h0));
      rd_exp_q.push_back({1'b0, 32'hC0DE0080 + 32'(i)});
    end
    push_req(1'b0, 1'b0, 4'd8, 4'hF, 32'h200);
    repeat (30) @(negedge clk_i);
    check("full_beats", beat_cnt - base, 4);
    check("full_stb_low", {wb_cyc_o, wb_stb_o}, 2'b00);
    check("full_dout_valid", dout_valid, 1'b1);
    pop_en = 1'b1;
    wait_idle("full", 80);
    wait_rd_drain("full", 20);
    check("full_total_beats", beat_cnt - base, 8);

    // Write len 4 with error on beat 2, then drain and recover
    push_din(32'hAAAA_0001);
    push_din(32'hBBBB_0002);
    base = beat_cnt;
    err_at = base + 1;
    bus_exp_q.push_back(beat(1'b1, 30'hC0, 4'hF, 3'b010, 2'b00, 32'hAAAA_0001));
    bus_exp_q.push_back(beat(1'b1, 30'hC1, 4'hF, 3'b010, 2'b00, 32'hBBBB_0002));
    push_req(1'b1, 1'b0, 4'd4, 4'hF, 32'h300);
    n = 0;
    while (state_dbg != 2'd2 && n < 40) begin @(negedge clk_i); n++; end
    err_at = -1;
    check("werr_drain_state", state_dbg, 2'd2);
    check("werr_err_o", err_o, 1'b1);
    push_din(32'hCCCC_0003);
    push_din(32'hDDDD_0004);
    repeat (3) @(negedge clk_i);
    check("werr_back_idle", state_dbg, 2'd0);
    check("werr_din_dropped", wb_dat_o, 32'h0);
    check("werr_no_beat3", beat_cnt - base, 2);
    push_din(32'hEEEE_0005);
    bus_exp_q.push_back(beat(1'b1, 30'h100, 4'hF, 3'b111, 2'b00, 32'hEEEE_0005));
    push_req(1'b1, 1'b0, 4'd1, 4'hF, 32'h400);
    wait_idle("werr_next", 30);
    check("werr_err_sticky", err_o, 1'b1);
    @(negedge clk_i); err_clr = 1'b1;
    @(negedge clk_i); err_clr = 1'b0;
    check("werr_err_cleared", err_o, 1'b0);

    // Read len 2 with error on beat 1: one errored dout entry, burst aborted
    base = beat_cnt;
    err_at = base;
    bus_exp_q.push_back(beat(1'b0, 30'h200, 4'hF, 3'b010, 2'b00, 32'h0));
    rd_exp_q.push_back({1'b1, 32'hC0DE0200});
    push_req(1'b0, 1'b0, 4'd2, 4'hF, 32'h800);
    wait_idle("rerr", 30);
    wait_rd_drain("rerr", 20);
    err_at = -1;
    check("rerr_beats", beat_cnt - base, 1);
    check("rerr_err_o", err_o, 1'b1);
    @(negedge clk_i); err_clr = 1'b1;
    @(negedge clk_i); err_clr = 1'b0;

    // Zero-length request discarded, then len 1 read with timing check
    base = beat_cnt;
    push_req(1'b0, 1'b0, 4'd0, 4'hF, 32'h500);
    wait_idle("zero", 10);
    repeat (3) @(negedge clk_i);
    check("zero_no_beat", beat_cnt - base, 0);
    bus_exp_q.push_back(beat(1'b0, 30'h140, 4'hF, 3'b111, 2'b00, 32'h0));
    rd_exp_q.push_back({1'b0, 32'hC0DE0140});
    push_req(1'b0, 1'b0, 4'd1, 4'hF, 32'h500);
    check("lat_c1_stb", wb_stb_o, 1'b0);
    @(negedge clk_i);
    check("lat_c2_stb", {wb_stb_o, state_dbg}, 3'b001);
    @(negedge clk_i);
    check("lat_c3_stb", wb_stb_o, 1'b1);
    wait_idle("one", 20);
    wait_rd_drain("one", 20);

    // Reset while stb is high mid-burst
    slave_stall = 1'b1;
    push_din(32'h5555_0001);
    push_req(1'b0, 1'b0, 4'd4, 4'hF, 32'h600);
    n = 0;
    while (!wb_stb_o && n < 20) begin @(negedge clk_i); n++; end
    check("rst_mid_stb_high", wb_stb_o, 1'b1);
    push_req(1'b0, 1'b0, 4'd2, 4'hF, 32'h900);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
    check("rst_mid_fifos", {req_ready, din_ready, dout_valid, busy, wb_dat_o}, {4'b1100, 32'h0});
    @(negedge clk_i);
    rst_ni = 1'b1;
    slave_stall = 1'b0;
    @(negedge clk_i);
    check("rst_rel_state", {req_ready, busy, state_dbg, wb_stb_o}, 5'b10000);
    bus_exp_q.push_back(beat(1'b0, 30'h1C0, 4'hF, 3'b111, 2'b00, 32'h0));
    rd_exp_q.push_back({1'b0, 32'hC0DE01C0});
    push_req(1'b0, 1'b0, 4'd1, 4'hF, 32'h700);
    wait_idle("post_rst", 20);
    wait_rd_drain("post_rst", 20);

    repeat (3) @(negedge clk_i);
    check("bus_q_empty", bus_exp_q.size(), 0);
    check("rd_q_empty", rd_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_burst_bridge.md
# wb_burst_bridge

Parametrised request-to-Wishbone bridge: accepts queued read/write burst requests from the CPU bus front end and replays them as Wishbone B4 registered-feedback cycles, buffering write data and read data in internal FIFOs. It generalises the 4-beat translator with configurable width, depth and burst length, linear/wrapping bursts, CTI/BTE tagging, bus-error termination, and backpressure on every input stream.

## Interface
- DW, 32, data width in bits (multiple of 8, ≥16); COLS = DW/8, AB = log2(COLS)
- AW, 32, byte address width
- FIFO_DEPTH, 8, entries per FIFO (power of two, ≥2)
- LEN_W, 4, burst length field width (max 2^LEN_W−1 beats)
- WRAP_BITS, 2, wrap-burst size = 2^WRAP_BITS beats (2..4)

- clk_i  in  1  clock (single clock domain)
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1 / 1  request push / request FIFO not full
- req_we, req_wrap  in  1 each  write, wrapping burst
- req_len  in  LEN_W  beat count
- req_mask  in  COLS  byte selects for all beats
- req_addr  in  AW  start byte address
- din_valid / din_ready  in / out  1 / 1  write-data push / din FIFO not full
- din  in  DW  write data
- dout_valid / dout_ack  out / in  1 / 1  read-data FIFO not empty / pop
- dout, dout_err  out  DW, 1  read-data head, head beat terminated by error
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each
- wb_sel_o  out  COLS;  wb_adr_o  out  AW−AB (word address)
- wb_dat_o  out  DW;  wb_cti_o  out  3;  wb_bte_o  out  2
- wb_ack_i, wb_err_i  in  1 each;  wb_dat_i  in  DW
- busy  out  1  state ≠ IDLE or request FIFO non-empty
- err_o  out  1  sticky bus-error flag;  err_clr  in  1  clears err_o

## Operation
- Three FIFOs, show-ahead: req (1+1+LEN_W+COLS+AW bits), din (DW), dout (DW+1). Push when full and pop when empty are ignored; simultaneous push/pop on a non-empty, non-full FIFO keeps occupancy.
- FSM states IDLE, XFER, DRAIN.
- IDLE: if req FIFO non-empty, pop head into working registers (we, wrap, len, mask, word address = addr[AW−1:AB]); len==0 → discard, stay IDLE; else → XFER.
- XFER, each cycle: wb_stb_o/wb_cyc_o registered = (!we & dout FIFO not full) | (we & din FIFO not empty); adr/sel/we/cti/bte registered from working set.
- Beat ends on stb & (ack | err): stb cleared next cycle; write pops din; read pushes {err, wb_dat_i} to dout.
- Address step after ack: linear → word address +1 modulo 2^(AW−AB); wrap → low WRAP_BITS +1 modulo 2^WRAP_BITS, upper bits held.
- len decrements per acked beat; acked beat with len==1 → IDLE.
- err on a beat: err_o set, burst aborted (no further beats). Read → IDLE. Write with remaining beats r = len−1 > 0 → DRAIN, popping r din entries as they arrive, then IDLE; r==0 → IDLE.
- wb_cti_o = 3'b111 when len==1, else 3'b010. wb_bte_o = 0 linear, WRAP_BITS−1 wrap.
- err_clr and a new error in the same cycle: err_o stays 1.
- wb_dat_o / dout driven to zero while their FIFO is empty.

## Timing
- Reset (async assert, sync-released): state IDLE, all FIFOs empty, err_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, sel/adr/cti/bte/dat_o=0, dout=0, dout_err=0, dout_valid=0, req_ready=din_ready=1, busy=0. Reset mid-burst drops cyc/stb immediately; bus transaction abandoned.
- req push at cycle 0 → popped cycle 1 → XFER cycle 2 → earliest stb cycle 3.
- Zero-wait slave: one beat every 2 cycles (stb, ack, stb low, stb again).
- Read: acked data visible on dout/dout_valid the cycle after ack.
- Write: din FIFO empty mid-burst → stb stays low (cyc low) until data arrives; dout FIFO full on read → same.
- ack and err asserted together: treated as err.
- ack/err while stb low: ignored.

## Test plan
- Linear read len=4, addr=0x100, zero-wait slave → adr 0x40..0x43, cti 010,010,010,111, four dout entries, dout_err=0, busy falls after last ack.
- Wrap write len=4, addr=0x10C, WRAP_BITS=2 → adr 0x43,0x40,0x41,0x42, bte=01, din popped in order, mask on every beat.
- Read len=8 with FIFO_DEPTH=4 and dout_ack held low → exactly 4 beats issued, stb stays low until a pop, remaining 4 then complete.
- Write len=4, wb_err_i on beat 2 → err_o=1, no beat 3, next 2 din pushes discarded, following request executes normally; err_clr clears err_o.
- Zero-length request then len=1 read → first produces no bus cycle, second one beat with cti=111.
- Reset asserted while stb high mid-burst → cyc/stb low same cycle, all FIFOs empty, req_ready=1 after release.
